key_event_decoder: RTL
======================

// Module: key_event_decoder
// PURPOSE
//   Consumes the debounced key interface (key_flag one-cycle event pulse, key_state level, 0 = pressed)
//   and classifies gestures into single-cycle event pulses: short press, long press, double click.
//   Sits between the key debounce filter and user logic (menus, RAM address stepping, mode select).
//   Assumes key_flag/key_state already synchronised and debounced; no further filtering here.
// PARAMETERS
//   LONG_CYC    50_000_000  cycles a press must be held to count as long press (1 s @ 50 MHz)
//   DBL_CYC     12_500_000  max cycles from first release to second press for double click (250 ms)
//   REPEAT_CYC   5_000_000  auto-repeat period while long-held (100 ms); used only with KEY_REPEAT_EN
//   CNT_W       26          counter width; must satisfy 2**CNT_W > max(LONG_CYC, DBL_CYC, REPEAT_CYC)
// PORTS
//   Clk          in   1  system clock
//   Rst_n        in   1  asynchronous active-low reset
//   key_flag     in   1  one-cycle pulse: key changed state (from debounce filter)
//   key_state    in   1  debounced level, 0 = pressed, 1 = released; sampled when key_flag = 1
//   short_press  out  1  one-cycle pulse: single click completed
//   long_press   out  1  one-cycle pulse: hold reached LONG_CYC
//   double_click out  1  one-cycle pulse: second click released
//   repeat_press out  1  one-cycle pulse every REPEAT_CYC while long-held (tied 0 without KEY_REPEAT_EN)
//   key_busy     out  1  level: 1 while a gesture is in progress (state != IDLE)
// BEHAVIOUR
//   Events: press = key_flag & ~key_state; release = key_flag & key_state. All outputs registered.
//   Reset: all outputs 0, state IDLE, counter 0; reset mid-gesture discards the gesture, no pulse emitted.
//   States (one-hot, 5 bits):
//     IDLE        : press -> PRESSED, cnt <= 0. release ignored.
//     PRESSED     : cnt++ each cycle. release -> WAIT_SECOND, cnt <= 0.
//                   cnt == LONG_CYC-1 (no release) -> long_press next cycle, -> LONG_HELD, cnt <= 0.
//     LONG_HELD   : release -> IDLE. No short_press/double_click after a long press.
//     WAIT_SECOND : cnt++. press -> SECOND_PRESSED. cnt == DBL_CYC-1 -> short_press, -> IDLE.
//     SECOND_PR   : release -> double_click, -> IDLE (regardless of hold length; no long_press here).
//   Latency: press at cycle T, held -> long_press high at T+LONG_CYC. Release at R, no second press ->
//   short_press high at R+DBL_CYC. Second release at S -> double_click high at S+1.
//   Boundaries: release on same cycle cnt hits LONG_CYC-1 -> release wins (short path, no long_press).
//   Press on same cycle cnt hits DBL_CYC-1 -> press wins (double-click path, no short_press).
//   Inconsistent events (press while pressed, release while released) ignored; state unchanged.
//   Counter saturates never needed: every counting state exits at its compare; counter cleared on exit.
//   Illegal state encoding -> IDLE, outputs 0. At most one of the pulse outputs is high per cycle.
// CONFIGURATION
//   KEY_REPEAT_EN defined: in LONG_HELD, repeat counter runs; repeat_press pulses at
//   T+LONG_CYC+k*REPEAT_CYC (k>=1) until release; release on a compare cycle suppresses that pulse.
//   Undefined: repeat logic absent, repeat_press constant 0, REPEAT_CYC unused.
// STRUCTURE
//   Shared header key_event_defs.vh: one-hot state localparams, press/release event macros,
//   default timing constants (50 MHz base) reused by other key consumers.
//   Sub-module evt_timer (CNT_W counter: clr, en, compare value in, hit out) instantiated once for
//   gesture timing and once more for repeat timing when KEY_REPEAT_EN is defined.
// TESTING  (bench params LONG_CYC=100, DBL_CYC=40, REPEAT_CYC=20)
//   1 press @0, release @30 -> short_press exactly at cycle 70; no other pulses.
//   2 press @0, hold -> long_press at cycle 100; release @150 -> no further pulses, key_busy low @151.
//   3 press @0, release @20, press @50, release @60 -> double_click at 61; no short_press.
//   4 press @0, release @99 -> release wins, no long_press; press exactly 39 cyc after release -> double path.
//   5 KEY_REPEAT_EN: press @0, release @165 -> long_press @100, repeat_press @120,140,160; none after.
//   6 Rst_n low @50 during PRESSED -> outputs 0 immediately; release @60 ignored; no pulse emitted.

Source files
------------

// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for key gesture consumers: one-hot decoder states, default
// 50 MHz timing constants and the press/release event helpers.
package key_event_decoder_pkg;

  typedef enum logic [4:0] {
    ST_IDLE        = 5'b00001,
    ST_PRESSED     = 5'b00010,
    ST_LONG_HELD   = 5'b00100,
    ST_WAIT_SECOND = 5'b01000,
    ST_SECOND_PR   = 5'b10000
  } state_e;

  localparam int unsigned DEF_LONG_CYC   = 50_000_000;  // 1 s
  localparam int unsigned DEF_DBL_CYC    = 12_500_000;  // 250 ms
  localparam int unsigned DEF_REPEAT_CYC = 5_000_000;   // 100 ms
  localparam int unsigned DEF_CNT_W      = 26;

  function automatic logic is_press(input logic flag, input logic level);
    return flag & ~level;
  endfunction

  function automatic logic is_release(input logic flag, input logic level);
    return flag & level;
  endfunction

endpackage

// File: rtl/evt_timer.sv
// Interval counter for gesture timing: clear has priority, counts while enabled,
// hit_o flags the cycle in which the count equals the compare value.
module evt_timer #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hit_o = en_i && (cnt_q == cmp_i);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key events into short-press, long-press and double-click pulses.
// Define KEY_REPEAT_EN to add auto-repeat pulses while the key is long-held.
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
  parameter int unsigned DBL_CYC    = DEF_DBL_CYC,
`ifdef KEY_REPEAT_EN
  parameter int unsigned REPEAT_CYC = DEF_REPEAT_CYC,
`endif
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_press,
  output logic key_busy
);

  // The gesture counter restarts the cycle after the triggering event, and the
  // pulse is registered one cycle after the compare, hence the two-cycle offset.
  localparam logic [CNT_W-1:0] LONG_CMP = CNT_W'(LONG_CYC - 2);
  localparam logic [CNT_W-1:0] DBL_CMP  = CNT_W'(DBL_CYC - 2);

  state_e state_q, state_d;
  logic   press, release_evt;
  logic   g_en, g_clr, g_hit;
  logic   [CNT_W-1:0] g_cmp;
  logic   rep_hit;
  logic   short_d, long_d, dbl_d, rep_d, busy_d;
  logic   short_q, long_q, dbl_q, rep_q, busy_q;

  assign press       = is_press(key_flag, key_state);
  assign release_evt = is_release(key_flag, key_state);

  assign g_en  = (state_q == ST_PRESSED) || (state_q == ST_WAIT_SECOND);
  assign g_cmp = (state_q == ST_PRESSED) ? LONG_CMP : DBL_CMP;
  assign g_clr = (state_d != state_q);

  evt_timer #(.CNT_W(CNT_W)) u_gesture_timer (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr_i (g_clr),
    .en_i  (g_en),
    .cmp_i (g_cmp),
    .hit_o (g_hit)
  );

`ifdef KEY_REPEAT_EN
  logic rep_en, rep_clr;

  // Repeat interval is measured from the long-press pulse and rearms on every hit.
  assign rep_en  = (state_q == ST_LONG_HELD);
  assign rep_clr = ~rep_en | rep_hit;

  evt_timer #(.CNT_W(CNT_W)) u_repeat_timer (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr_i (rep_clr),
    .en_i  (rep_en),
    .cmp_i (CNT_W'(REPEAT_CYC - 1)),
    .hit_o (rep_hit)
  );
`else
  assign rep_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        // A release on the compare cycle wins over the long press.
        if (release_evt) begin
          state_d = ST_WAIT_SECOND;
        end else if (g_hit) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (release_evt) begin
          state_d = ST_IDLE;
        end else if (rep_hit) begin
          rep_d = 1'b1;
        end
      end
      ST_WAIT_SECOND: begin
        if (press) begin
          state_d = ST_SECOND_PR;
        end else if (g_hit) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SECOND_PR: begin
        if (release_evt) begin
          dbl_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      rep_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign repeat_press = rep_q;
  assign key_busy     = busy_q;

endmodule
